// File: rtl/dut_stim_sched.sv
// Stimulus scheduler: drives LFSR operands into a datapath, holds each vector for
// SETTLE cycles, then folds the 69-bit result into a 32-bit MISR.
// Optional golden-signature compare is enabled by defining SCHED_GOLDEN_CMP_EN.
module dut_stim_sched #(
    parameter int unsigned NUM_VEC = 256,
    parameter int unsigned SETTLE  = 1,
    parameter logic [63:0] SEED    = 64'h1
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef SCHED_GOLDEN_CMP_EN
    input  logic [31:0]         golden,
    output logic                mismatch,
`endif
    input  logic                start,
    input  logic                abort,
    output logic [18:0]         op0,
    output logic signed [15:0]  op1,
    output logic signed [8:0]   op2,
    output logic signed [7:0]   op3,
    input  logic [68:0]         y_in,
    output logic                busy,
    output logic                done,
    output logic [15:0]         vec_cnt,
    output logic [31:0]         signature
);

    localparam logic [63:0] LFSR_MASK   = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_EFF    = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [15:0] NUM_VEC_W   = 16'(NUM_VEC);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [31:0] MISR_POLY   = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [63:0]         lfsr_reg;
    logic [3:0]          settle_reg;
    logic [15:0]         vec_cnt_reg;
    logic [31:0]         misr_reg;
    logic [18:0]         op0_reg;
    logic signed [15:0]  op1_reg;
    logic signed [8:0]   op2_reg;
    logic signed [7:0]   op3_reg;

    logic [63:0]         lfsr_adv;
    logic [63:0]         op_src;
    logic [31:0]         fold;
    logic [31:0]         misr_adv;
    logic [15:0]         vec_cnt_inc;
    logic                last_vec;
    logic                start_acc;

    // Fold the 69-bit result down to 32 bits; only the low 5 lanes see the top bits.
    for (genvar gi = 0; gi < 32; gi++) begin : g_fold
        if (gi < 5) begin : g_wide
            assign fold[gi] = y_in[gi] ^ y_in[gi + 32] ^ y_in[gi + 64];
        end else begin : g_narrow
            assign fold[gi] = y_in[gi] ^ y_in[gi + 32];
        end
    end

    always_comb begin
        lfsr_adv    = {1'b0, lfsr_reg[63:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 64'd0);
        misr_adv    = {misr_reg[30:0], 1'b0} ^ (misr_reg[31] ? MISR_POLY : 32'd0) ^ fold;
        vec_cnt_inc = vec_cnt_reg + 16'd1;
        last_vec    = (vec_cnt_inc == NUM_VEC_W);
        start_acc   = (state_reg == IDLE) && start;
        // Operands come from the seed on run start, otherwise from the stepped LFSR.
        op_src      = (state_reg == IDLE) ? SEED_EFF : lfsr_adv;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_reg == SETTLE_LAST) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_vec) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lfsr_reg    <= 64'd0;
            settle_reg  <= 4'd0;
            vec_cnt_reg <= 16'd0;
            misr_reg    <= 32'd0;
            op0_reg     <= '0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            op3_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (start_acc) begin
                lfsr_reg    <= SEED_EFF;
                vec_cnt_reg <= 16'd0;
                misr_reg    <= 32'd0;
                settle_reg  <= 4'd0;
                op0_reg     <= op_src[18:0];
                op1_reg     <= op_src[34:19];
                op2_reg     <= op_src[43:35];
                op3_reg     <= op_src[51:44];
            end else if (state_reg == DRIVE && !abort && settle_reg != SETTLE_LAST) begin
                settle_reg <= settle_reg + 4'd1;
            end else if (state_reg == CAPTURE && !abort) begin
                misr_reg    <= misr_adv;
                vec_cnt_reg <= vec_cnt_inc;
                if (!last_vec) begin
                    lfsr_reg   <= lfsr_adv;
                    settle_reg <= 4'd0;
                    op0_reg    <= op_src[18:0];
                    op1_reg    <= op_src[34:19];
                    op2_reg    <= op_src[43:35];
                    op3_reg    <= op_src[51:44];
                end
            end
        end
    end

`ifdef SCHED_GOLDEN_CMP_EN
    logic mismatch_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_reg <= 1'b0;
        end else if (start_acc) begin
            mismatch_reg <= 1'b0;
        end else if (state_reg == DONE && misr_reg != golden) begin
            mismatch_reg <= 1'b1;
        end
    end

    assign mismatch = mismatch_reg;
`endif

    assign op0       = op0_reg;
    assign op1       = op1_reg;
    assign op2       = op2_reg;
    assign op3       = op3_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign vec_cnt   = vec_cnt_reg;
    assign signature = misr_reg;

endmodule

// File: tb/tb_dut_stim_sched.sv
// Self-checking bench for dut_stim_sched: three instances with different sizing,
// scoreboard of expected (vec_cnt, signature) pairs popped on each done pulse.
module tb_dut_stim_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance a: NUM_VEC=4, SETTLE=1, SEED=1
    logic start_a, abort_a, busy_a, done_a;
    logic [68:0] y_a;
    logic [18:0] op0_a;
    logic signed [15:0] op1_a;
    logic signed [8:0] op2_a;
    logic signed [7:0] op3_a;
    logic [15:0] vec_a;
    logic [31:0] sig_a;

    // Instance b: NUM_VEC=1, SETTLE=2, SEED=0 (replaced by 1)
    logic start_b, abort_b, busy_b, done_b;
    logic [68:0] y_b;
    logic [18:0] op0_b;
    logic signed [15:0] op1_b;
    logic signed [8:0] op2_b;
    logic signed [7:0] op3_b;
    logic [15:0] vec_b;
    logic [31:0] sig_b;

    // Instance c: NUM_VEC=8, SETTLE=1, nonzero seed so operands are exercised
    logic start_c, abort_c, busy_c, done_c;
    logic [68:0] y_c;
    logic [18:0] op0_c;
    logic signed [15:0] op1_c;
    logic signed [8:0] op2_c;
    logic signed [7:0] op3_c;
    logic [15:0] vec_c;
    logic [31:0] sig_c;

    localparam logic [63:0] SEED_C = 64'h0123_4567_89AB_CDEF;

`ifdef SCHED_GOLDEN_CMP_EN
    logic [31:0] golden_b;
    logic mm_a, mm_b, mm_c;
`endif

    dut_stim_sched #(.NUM_VEC(4), .SETTLE(1), .SEED(64'h1)) dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef SCHED_GOLDEN_CMP_EN
        .golden(32'h0), .mismatch(mm_a),
`endif
        .start(start_a), .abort(abort_a),
        .op0(op0_a), .op1(op1_a), .op2(op2_a), .op3(op3_a),
        .y_in(y_a), .busy(busy_a), .done(done_a), .vec_cnt(vec_a), .signature(sig_a)
    );

    dut_stim_sched #(.NUM_VEC(1), .SETTLE(2), .SEED(64'h0)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef SCHED_GOLDEN_CMP_EN
        .golden(golden_b), .mismatch(mm_b),
`endif
        .start(start_b), .abort(abort_b),
        .op0(op0_b), .op1(op1_b), .op2(op2_b), .op3(op3_b),
        .y_in(y_b), .busy(busy_b), .done(done_b), .vec_cnt(vec_b), .signature(sig_b)
    );

    dut_stim_sched #(.NUM_VEC(8), .SETTLE(1), .SEED(SEED_C)) dut_c (
        .clk(clk), .rst_n(rst_n),
`ifdef SCHED_GOLDEN_CMP_EN
        .golden(32'h0), .mismatch(mm_c),
`endif
        .start(start_c), .abort(abort_c),
        .op0(op0_c), .op1(op1_c), .op2(op2_c), .op3(op3_c),
        .y_in(y_c), .busy(busy_c), .done(done_c), .vec_cnt(vec_c), .signature(sig_c)
    );

    typedef struct {
        logic [15:0] cnt;
        logic [31:0] sig;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        logic [63:0] n;
        n = l >> 1;
        if (l[0]) begin
            n[63] = ~n[63];
            n[62] = ~n[62];
            n[60] = ~n[60];
            n[59] = ~n[59];
        end
        return n;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [68:0] y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {27'b0, y[68:64]};
        return {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_checks++; if (vec_a !== 16'd0) begin n_fail++; $display("FAIL reset_vec_cnt: got %0d expected 0", vec_a); end
        n_checks++; if (sig_a !== 32'd0) begin n_fail++; $display("FAIL reset_signature: got %h expected 0", sig_a); end
        n_checks++; if (op0_a !== 19'd0) begin n_fail++; $display("FAIL reset_op0: got %h expected 0", op0_a); end
        n_checks++; if (op1_a !== 16'sd0) begin n_fail++; $display("FAIL reset_op1: got %h expected 0", op1_a); end
        n_checks++; if (op2_a !== 9'sd0) begin n_fail++; $display("FAIL reset_op2: got %h expected 0", op2_a); end
        n_checks++; if (op3_a !== 8'sd0) begin n_fail++; $display("FAIL reset_op3: got %h expected 0", op3_a); end
        n_checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0) begin n_fail++; $display("FAIL reset_busy_bc: got %b%b expected 00", busy_b, busy_c); end
        rst_n = 1'b1;
        tick();
        $display("reset: busy=%b done=%b vec_cnt=%0d signature=%h", busy_a, done_a, vec_a, sig_a);
    endtask

    // NUM_VEC=4, SETTLE=1, y_in=0: done exactly at cycle 9, optionally with a stray start at cycle 3.
    task automatic run_a_short(input bit extra_start, input string tag);
        exp_t e, got;
        e.cnt = 16'd4;
        e.sig = 32'd0;
        sb_q.push_back(e);
        y_a = '0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            n_checks++; if (done_a !== (cyc == 9)) begin n_fail++; $display("FAIL %s_done cyc=%0d: got %b expected %b", tag, cyc, done_a, (cyc == 9)); end
            n_checks++; if (busy_a !== (cyc <= 9)) begin n_fail++; $display("FAIL %s_busy cyc=%0d: got %b expected %b", tag, cyc, busy_a, (cyc <= 9)); end
            if (done_a === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL %s_sb: done with empty scoreboard", tag);
                end else begin
                    got = sb_q.pop_front();
                    if (vec_a !== got.cnt || sig_a !== got.sig) begin
                        n_fail++; $display("FAIL %s_result: got cnt=%0d sig=%h expected cnt=%0d sig=%h", tag, vec_a, sig_a, got.cnt, got.sig);
                    end
                    $display("%s: done at cycle %0d vec_cnt=%0d signature=%h", tag, cyc, vec_a, sig_a);
                end
            end
            start_a = extra_start && (cyc == 3);
            tick();
        end
        start_a = 1'b0;
    endtask

    task automatic test_short_run;
        run_a_short(1'b0, "short_run");
    endtask

    task automatic test_start_while_busy;
        run_a_short(1'b1, "start_busy");
    endtask

    task automatic test_const_input;
        exp_t e, got;
        e.cnt = 16'd1;
        e.sig = 32'h0000_0001;
        sb_q.push_back(e);
        y_b = 69'h1;
`ifdef SCHED_GOLDEN_CMP_EN
        golden_b = 32'h0000_0001;
`endif
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        // Seed of zero is replaced by one.
        n_checks++; if (op0_b !== 19'd1) begin n_fail++; $display("FAIL const_seed0_op0: got %h expected 1", op0_b); end
        for (int cyc = 1; cyc <= 6; cyc++) begin
            n_checks++; if (done_b !== (cyc == 4)) begin n_fail++; $display("FAIL const_done cyc=%0d: got %b expected %b", cyc, done_b, (cyc == 4)); end
            if (done_b === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL const_sb: done with empty scoreboard");
                end else begin
                    got = sb_q.pop_front();
                    if (vec_b !== got.cnt || sig_b !== got.sig) begin
                        n_fail++; $display("FAIL const_result: got cnt=%0d sig=%h expected cnt=%0d sig=%h", vec_b, sig_b, got.cnt, got.sig);
                    end
                    $display("const_input: done at cycle %0d vec_cnt=%0d signature=%h", cyc, vec_b, sig_b);
                end
            end
            tick();
        end
        n_checks++; if (sig_b !== 32'h0000_0001) begin n_fail++; $display("FAIL const_sig_hold: got %h expected 00000001", sig_b); end
    endtask

    // Full NUM_VEC=8 run on c with random results; operands checked against an LFSR model.
    task automatic test_lfsr_ops;
        logic [68:0] ys[8];
        logic [63:0] lm;
        logic [31:0] mm;
        exp_t e, got;
        int k;
        mm = 32'd0;
        for (int i = 0; i < 8; i++) begin
            ys[i] = {5'($urandom), $urandom, $urandom};
            mm = misr_step(mm, ys[i]);
        end
        e.cnt = 16'd8;
        e.sig = mm;
        sb_q.push_back(e);
        lm = SEED_C;
        y_c = ys[0];
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            k = (cyc - 1) / 2;
            if (cyc <= 16) begin
                n_checks++;
                if (op0_c !== lm[18:0] || op1_c !== lm[34:19] || op2_c !== lm[43:35] || op3_c !== lm[51:44]) begin
                    n_fail++;
                    $display("FAIL lfsr_ops cyc=%0d: got %h %h %h %h expected %h %h %h %h", cyc,
                             op0_c, op1_c, op2_c, op3_c, lm[18:0], lm[34:19], lm[43:35], lm[51:44]);
                end
            end
            n_checks++; if (done_c !== (cyc == 17)) begin n_fail++; $display("FAIL lfsr_done cyc=%0d: got %b expected %b", cyc, done_c, (cyc == 17)); end
            if (done_c === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL lfsr_sb: done with empty scoreboard");
                end else begin
                    got = sb_q.pop_front();
                    if (vec_c !== got.cnt || sig_c !== got.sig) begin
                        n_fail++; $display("FAIL lfsr_result: got cnt=%0d sig=%h expected cnt=%0d sig=%h", vec_c, sig_c, got.cnt, got.sig);
                    end
                    $display("lfsr_ops: done at cycle %0d vec_cnt=%0d signature=%h", cyc, vec_c, sig_c);
                end
            end
            tick();
            if ((cyc % 2) == 0 && cyc < 16) begin
                lm = lfsr_step(lm);
                y_c = ys[k + 1];
            end
        end
    endtask

    task automatic test_abort;
        logic [68:0] yv;
        logic [31:0] m2;
        yv = 69'h1F_DEAD_BEEF_0123_4567;
        m2 = misr_step(misr_step(32'd0, yv), yv);
        y_c = yv;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            abort_c = (cyc == 5);
            tick();
        end
        abort_c = 1'b0;
        n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy_c); end
        n_checks++; if (vec_c !== 16'd2) begin n_fail++; $display("FAIL abort_vec_cnt: got %0d expected 2", vec_c); end
        n_checks++; if (sig_c !== m2) begin n_fail++; $display("FAIL abort_signature: got %h expected %h", sig_c, m2); end
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (done_c !== 1'b0) begin n_fail++; $display("FAIL abort_no_done +%0d: got %b expected 0", i, done_c); end
            tick();
        end
        n_checks++; if (vec_c !== 16'd2 || sig_c !== m2) begin n_fail++; $display("FAIL abort_frozen: got cnt=%0d sig=%h expected cnt=2 sig=%h", vec_c, sig_c, m2); end
        $display("abort: busy=%b vec_cnt=%0d signature=%h", busy_c, vec_c, sig_c);
    endtask

    // Abort in the CAPTURE that would reach the terminal count wins over DONE.
    task automatic test_abort_terminal;
        y_b = 69'h1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            abort_b = (cyc == 3);
            tick();
        end
        abort_b = 1'b0;
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL abort_term_busy: got %b expected 0", busy_b); end
        n_checks++; if (vec_b !== 16'd0) begin n_fail++; $display("FAIL abort_term_vec_cnt: got %0d expected 0", vec_b); end
        n_checks++; if (sig_b !== 32'd0) begin n_fail++; $display("FAIL abort_term_signature: got %h expected 0", sig_b); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL abort_term_no_done +%0d: got %b expected 0", i, done_b); end
            tick();
        end
        $display("abort_terminal: busy=%b vec_cnt=%0d signature=%h", busy_b, vec_b, sig_b);
    endtask

    task automatic test_reset_midrun;
        y_a = 69'h3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) tick();
        rst_n = 1'b0;
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        rst_n = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
        n_checks++; if (vec_a !== 16'd0 || sig_a !== 32'd0) begin n_fail++; $display("FAIL midrst_clear: got cnt=%0d sig=%h expected 0 0", vec_a, sig_a); end
        n_checks++; if (op0_a !== 19'd0) begin n_fail++; $display("FAIL midrst_op0: got %h expected 0", op0_a); end
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_idle +%0d: got done=%b busy=%b expected 0 0", i, done_a, busy_a); end
            tick();
        end
        $display("reset_midrun: busy=%b vec_cnt=%0d", busy_a, vec_a);
    endtask

`ifdef SCHED_GOLDEN_CMP_EN
    task automatic test_golden;
        exp_t e, got;
        e.cnt = 16'd1;
        e.sig = 32'h0000_0001;
        sb_q.push_back(e);
        y_b = 69'h1;
        golden_b = 32'h0000_0002;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            n_checks++; if (mm_b !== (cyc >= 5)) begin n_fail++; $display("FAIL golden_mismatch cyc=%0d: got %b expected %b", cyc, mm_b, (cyc >= 5)); end
            if (done_b === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL golden_sb: done with empty scoreboard");
                end else begin
                    got = sb_q.pop_front();
                    if (sig_b !== got.sig) begin n_fail++; $display("FAIL golden_result: got sig=%h expected %h", sig_b, got.sig); end
                end
            end
            tick();
        end
        golden_b = 32'h0000_0001;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n_checks++; if (mm_b !== 1'b0) begin n_fail++; $display("FAIL golden_clear_on_start: got %b expected 0", mm_b); end
        for (int cyc = 2; cyc <= 6; cyc++) tick();
        n_checks++; if (mm_b !== 1'b0) begin n_fail++; $display("FAIL golden_match: got %b expected 0", mm_b); end
        $display("golden: mismatch=%b signature=%h", mm_b, sig_b);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; y_a = '0;
        start_b = 1'b0; abort_b = 1'b0; y_b = '0;
        start_c = 1'b0; abort_c = 1'b0; y_c = '0;
`ifdef SCHED_GOLDEN_CMP_EN
        golden_b = 32'h0000_0001;
`endif
        test_reset();
        test_short_run();
        test_const_input();
        test_lfsr_ops();
        test_abort();
        test_abort_terminal();
        test_start_while_busy();
        test_reset_midrun();
`ifdef SCHED_GOLDEN_CMP_EN
        test_golden();
`endif
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
